// File: rtl/flex_down_counter.sv
// Loadable down-counter/timer with IDLE/RUN/DONE states, one-shot or auto-reload operation.
// Optional expire_pulse output enabled by defining FLEX_DOWN_EXPIRE_PULSE_EN.
module flex_down_counter #(
    parameter int NUM_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    auto_reload,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    zero_flag,
    output logic                    busy
`ifdef FLEX_DOWN_EXPIRE_PULSE_EN
    ,
    output logic                    expire_pulse
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

    state_t                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
    logic                    zero_q, zero_d;
    logic                    busy_q, busy_d;
    logic                    expire_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        expire_d = 1'b0;

        if (clear) begin
            state_d  = IDLE;
            count_d  = CNT_ZERO;
            reload_d = CNT_ZERO;
            zero_d   = 1'b0;
            busy_d   = 1'b0;
        end else if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            if (load_val != CNT_ZERO) begin
                state_d = RUN;
                zero_d  = 1'b0;
                busy_d  = 1'b1;
            end else begin
                // Zero load goes straight to DONE without an expiry event.
                state_d = DONE;
                zero_d  = 1'b1;
                busy_d  = 1'b0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (count_enable) begin
                        if (count_q > CNT_ONE) begin
                            count_d = count_q - CNT_ONE;
                        end else if (count_q == CNT_ONE) begin
                            count_d  = CNT_ZERO;
                            zero_d   = 1'b1;
                            expire_d = 1'b1;
                            if (auto_reload) begin
                                busy_d = 1'b1;
                            end else begin
                                state_d = DONE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            // Sitting at 0 in RUN only happens in periodic mode: restart the period.
                            count_d = reload_q;
                            zero_d  = 1'b0;
                        end
                    end
                end
                DONE: begin
                    count_d = CNT_ZERO;
                    zero_d  = 1'b1;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    count_d = CNT_ZERO;
                    zero_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
        end
    end

    assign count_out = count_q;
    assign zero_flag = zero_q;
    assign busy      = busy_q;

`ifdef FLEX_DOWN_EXPIRE_PULSE_EN
    logic expire_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expire_q <= 1'b0;
        end else begin
            expire_q <= expire_d;
        end
    end

    assign expire_pulse = expire_q;
`else
    logic unused_expire;
    assign unused_expire = expire_d;
`endif

endmodule

// File: tb/tb_flex_down_counter.sv
// Directed self-checking bench for flex_down_counter (default width 8).
// Checks expire_pulse as well when FLEX_DOWN_EXPIRE_PULSE_EN is defined.
module tb_flex_down_counter;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic       count_enable;
    logic       auto_reload;
    logic [7:0] count_out;
    logic       zero_flag;
    logic       busy;
`ifdef FLEX_DOWN_EXPIRE_PULSE_EN
    logic       expire_pulse;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    flex_down_counter #(.NUM_CNT_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .auto_reload  (auto_reload),
        .count_out    (count_out),
        .zero_flag    (zero_flag),
        .busy         (busy)
`ifdef FLEX_DOWN_EXPIRE_PULSE_EN
        ,
        .expire_pulse (expire_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; all checks happen 1 time unit after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got cnt=%0d z=%0b b=%0b, want cnt=0 z=0 b=0", count_out, zero_flag, busy);
        end
        rst = 1'b0;
        count_enable = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_ignores_enable: got cnt=%0d z=%0b b=%0b, want cnt=0 z=0 b=0", count_out, zero_flag, busy);
        end
        load = 1'b1; load_val = 8'd5; count_enable = 1'b0;
        tick();
        load = 1'b0;
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd5, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL load5: got cnt=%0d z=%0b b=%0b, want cnt=5 z=0 b=1", count_out, zero_flag, busy);
        end
        count_enable = 1'b1;
        tick();
        tick();
        n_checks++;
        if (count_out !== 8'd3) begin
            n_fail++;
            $display("FAIL midcount: got cnt=%0d, want cnt=3", count_out);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got cnt=%0d z=%0b b=%0b, want cnt=0 z=0 b=0", count_out, zero_flag, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset_idle: got cnt=%0d z=%0b b=%0b, want cnt=0 z=0 b=0", count_out, zero_flag, busy);
        end
        count_enable = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_one_shot();
        logic [7:0] exp_cnt;
        auto_reload = 1'b0; load = 1'b1; load_val = 8'd3; count_enable = 1'b1;
        tick();
        load = 1'b0;
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL oneshot_load: got cnt=%0d z=%0b b=%0b, want cnt=3 z=0 b=1", count_out, zero_flag, busy);
        end
        for (int i = 0; i < 13; i++) begin
            tick();
            exp_cnt = (i < 3) ? 8'(2 - i) : 8'd0;
            n_checks++;
            if ({count_out, zero_flag, busy} !== {exp_cnt, exp_cnt == 8'd0, exp_cnt != 8'd0}) begin
                n_fail++;
                $display("FAIL oneshot_step%0d: got cnt=%0d z=%0b b=%0b, want cnt=%0d z=%0b b=%0b",
                         i, count_out, zero_flag, busy, exp_cnt, exp_cnt == 8'd0, exp_cnt != 8'd0);
            end
`ifdef FLEX_DOWN_EXPIRE_PULSE_EN
            n_checks++;
            if (expire_pulse !== (i == 2)) begin
                n_fail++;
                $display("FAIL oneshot_expire%0d: got %0b, want %0b", i, expire_pulse, i == 2);
            end
`endif
        end
        count_enable = 1'b0;
        $display("test_one_shot done");
    endtask

    task automatic test_auto_reload();
        logic [7:0] exp_seq [5] = '{8'd1, 8'd0, 8'd2, 8'd1, 8'd0};
        auto_reload = 1'b1; load = 1'b1; load_val = 8'd2; count_enable = 1'b1;
        tick();
        load = 1'b0;
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd2, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL auto_load: got cnt=%0d z=%0b b=%0b, want cnt=2 z=0 b=1", count_out, zero_flag, busy);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({count_out, zero_flag, busy} !== {exp_seq[i], exp_seq[i] == 8'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL auto_step%0d: got cnt=%0d z=%0b b=%0b, want cnt=%0d z=%0b b=1",
                         i, count_out, zero_flag, busy, exp_seq[i], exp_seq[i] == 8'd0);
            end
`ifdef FLEX_DOWN_EXPIRE_PULSE_EN
            n_checks++;
            if (expire_pulse !== (exp_seq[i] == 8'd0)) begin
                n_fail++;
                $display("FAIL auto_expire%0d: got %0b, want %0b", i, expire_pulse, exp_seq[i] == 8'd0);
            end
`endif
        end
        count_enable = 1'b0;
        tick();
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL auto_hold_zero: got cnt=%0d z=%0b b=%0b, want cnt=0 z=1 b=1", count_out, zero_flag, busy);
        end
        $display("test_auto_reload done");
    endtask

    task automatic test_enable_gaps();
        logic       en_pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] exp_cnt [4] = '{8'd3, 8'd3, 8'd3, 8'd2};
        auto_reload = 1'b0; load = 1'b1; load_val = 8'd4; count_enable = 1'b0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            count_enable = en_pat[i];
            tick();
            n_checks++;
            if ({count_out, zero_flag, busy} !== {exp_cnt[i], 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL gaps_step%0d: got cnt=%0d z=%0b b=%0b, want cnt=%0d z=0 b=1",
                         i, count_out, zero_flag, busy, exp_cnt[i]);
            end
        end
        count_enable = 1'b0;
        $display("test_enable_gaps done");
    endtask

    task automatic test_priority();
        clear = 1'b1; load = 1'b1; load_val = 8'd9;
        tick();
        clear = 1'b0; load = 1'b0;
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_over_load: got cnt=%0d z=%0b b=%0b, want cnt=0 z=0 b=0", count_out, zero_flag, busy);
        end
        load = 1'b1; load_val = 8'd5; count_enable = 1'b1;
        tick();
        load = 1'b0;
        tick();
        n_checks++;
        if (count_out !== 8'd4) begin
            n_fail++;
            $display("FAIL prio_decrement: got cnt=%0d, want cnt=4", count_out);
        end
        load = 1'b1; load_val = 8'd7;
        tick();
        load = 1'b0; count_enable = 1'b0;
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd7, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL load_over_enable: got cnt=%0d z=%0b b=%0b, want cnt=7 z=0 b=1", count_out, zero_flag, busy);
        end
        $display("test_priority done");
    endtask

    task automatic test_zero_load();
        auto_reload = 1'b1; load = 1'b1; load_val = 8'd0; count_enable = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({count_out, zero_flag, busy} !== {8'd0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL zero_load%0d: got cnt=%0d z=%0b b=%0b, want cnt=0 z=1 b=0", i, count_out, zero_flag, busy);
            end
`ifdef FLEX_DOWN_EXPIRE_PULSE_EN
            n_checks++;
            if (expire_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_load_expire%0d: got %0b, want 0", i, expire_pulse);
            end
`endif
            tick();
        end
        load = 1'b1; load_val = 8'hFF; count_enable = 1'b0;
        tick();
        load = 1'b0; count_enable = 1'b1;
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd255, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL load_max: got cnt=%0d z=%0b b=%0b, want cnt=255 z=0 b=1", count_out, zero_flag, busy);
        end
        tick();
        count_enable = 1'b0;
        n_checks++;
        if (count_out !== 8'd254) begin
            n_fail++;
            $display("FAIL max_decrement: got cnt=%0d, want cnt=254", count_out);
        end
        $display("test_zero_load done");
    endtask

    task automatic test_back_to_back();
        auto_reload = 1'b0; load = 1'b1; load_val = 8'd1; count_enable = 1'b1;
        tick();
        load = 1'b0;
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_load1: got cnt=%0d z=%0b b=%0b, want cnt=1 z=0 b=1", count_out, zero_flag, busy);
        end
        tick();
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_expire: got cnt=%0d z=%0b b=%0b, want cnt=0 z=1 b=0", count_out, zero_flag, busy);
        end
`ifdef FLEX_DOWN_EXPIRE_PULSE_EN
        n_checks++;
        if (expire_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_expire_pulse: got %0b, want 1", expire_pulse);
        end
`endif
        load = 1'b1; load_val = 8'd2;
        tick();
        load = 1'b0;
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd2, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_reload_from_done: got cnt=%0d z=%0b b=%0b, want cnt=2 z=0 b=1", count_out, zero_flag, busy);
        end
        count_enable = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++;
        if ({count_out, zero_flag, busy} !== {8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_clear: got cnt=%0d z=%0b b=%0b, want cnt=0 z=0 b=0", count_out, zero_flag, busy);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = 8'd0;
        count_enable = 1'b0; auto_reload = 1'b0;
        tick();
        tick();
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_enable_gaps();
        test_priority();
        test_zero_load();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
